// File: rtl/axi_req_merge.sv
// axi_req_merge: arbitrates the AXI AW/AR channels into one locked request for the
// request packetizer, gating issue with per-TID same-ID ordering tables.
module axi_req_merge #(
    parameter int TIDS_M               = 16,
    parameter int ADDRESS_WIDTH        = 32,
    parameter int USER_WIDTH           = 2,
    parameter int EXT_SLAVES           = 2,
    parameter int MAX_OUTST            = 4,
    parameter int AXI_W_AWR_STD_FIELDS = 29,
    localparam int TW = (TIDS_M > 1) ? $clog2(TIDS_M) : 1,
    localparam int DW = (EXT_SLAVES > 1) ? $clog2(EXT_SLAVES) : 1,
    localparam int AW = TW + ADDRESS_WIDTH + USER_WIDTH + AXI_W_AWR_STD_FIELDS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] aw_chan,
    input  logic          aw_valid,
    output logic          aw_ready,
    input  logic [AW-1:0] ar_chan,
    input  logic          ar_valid,
    output logic          ar_ready,
    output logic [AW-1:0] addr_chan,
    input  logic [DW-1:0] addr_lut_dst,
    output logic [1:0]    active_select,
    output logic          reorder_qualify,
    input  logic          addr_ready,
    input  logic [1:0]    release_trans,
    input  logic          b_done_valid,
    input  logic [TW-1:0] b_done_tid,
    input  logic          r_done_valid,
    input  logic [TW-1:0] r_done_tid
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTST);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_r;
    logic [1:0]    sel_r;
    logic          prio_r;

    logic [CW-1:0] wr_cnt_r [TIDS_M];
    logic [DW-1:0] wr_dst_r [TIDS_M];
    logic [CW-1:0] rd_cnt_r [TIDS_M];
    logic [DW-1:0] rd_dst_r [TIDS_M];

    logic          locked_s;
    logic [TW-1:0] tid_s;
    logic [CW-1:0] cnt_sel_s;
    logic [DW-1:0] dst_sel_s;
    logic          wr_inc_s;
    logic          rd_inc_s;
    logic          b_zero_s;
    logic          r_zero_s;

    // A done against an empty entry is dropped so the count cannot wrap below zero.
    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                               input logic          inc,
                                               input logic          dec);
        logic          dec_eff;
        logic [CW-1:0] res;
        dec_eff = dec && (cnt != CNT_ZERO);
        case ({inc, dec_eff})
            2'b10:   res = cnt + CW'(1);
            2'b01:   res = cnt - CW'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Arbitration FSM: lock one direction until its release, then favour the other.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sel_r   <= 2'b00;
            prio_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (aw_valid && (!ar_valid || !prio_r)) begin
                        sel_r   <= 2'b01;
                        state_r <= LOCKED;
                    end else if (ar_valid) begin
                        sel_r   <= 2'b10;
                        state_r <= LOCKED;
                    end else begin
                        sel_r   <= 2'b00;
                        state_r <= IDLE;
                    end
                end
                LOCKED: begin
                    if ((release_trans & sel_r) != 2'b00) begin
                        state_r <= IDLE;
                        sel_r   <= 2'b00;
                        prio_r  <= sel_r[0];
                    end else begin
                        state_r <= LOCKED;
                        sel_r   <= sel_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sel_r   <= 2'b00;
                end
            endcase
        end
    end

    // Payload mux, handshake steering and same-ID qualification for the locked request.
    always_comb begin
        locked_s = (state_r == LOCKED);
        if (sel_r[1]) begin
            addr_chan = ar_chan;
        end else begin
            addr_chan = aw_chan;
        end
        tid_s = addr_chan[TW-1:0];
        if (sel_r[1]) begin
            cnt_sel_s = rd_cnt_r[tid_s];
            dst_sel_s = rd_dst_r[tid_s];
        end else begin
            cnt_sel_s = wr_cnt_r[tid_s];
            dst_sel_s = wr_dst_r[tid_s];
        end
        reorder_qualify = locked_s &&
                          ((cnt_sel_s == CNT_ZERO) ||
                           ((dst_sel_s == addr_lut_dst) && (cnt_sel_s < CNT_MAX)));
        aw_ready      = addr_ready & sel_r[0];
        ar_ready      = addr_ready & sel_r[1];
        active_select = sel_r;
        wr_inc_s      = addr_ready & locked_s & sel_r[0];
        rd_inc_s      = addr_ready & locked_s & sel_r[1];
        b_zero_s      = (wr_cnt_r[b_done_tid] == CNT_ZERO);
        r_zero_s      = (rd_cnt_r[r_done_tid] == CNT_ZERO);
    end

    // Outstanding tables: count up on accepted address, down on the final response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TIDS_M; i++) begin
                wr_cnt_r[i] <= CNT_ZERO;
                wr_dst_r[i] <= {DW{1'b0}};
                rd_cnt_r[i] <= CNT_ZERO;
                rd_dst_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < TIDS_M; i++) begin
                wr_cnt_r[i] <= next_cnt(wr_cnt_r[i],
                                        wr_inc_s && (tid_s == TW'(i)),
                                        b_done_valid && (b_done_tid == TW'(i)));
                rd_cnt_r[i] <= next_cnt(rd_cnt_r[i],
                                        rd_inc_s && (tid_s == TW'(i)),
                                        r_done_valid && (r_done_tid == TW'(i)));
                if (wr_inc_s && (tid_s == TW'(i))) begin
                    wr_dst_r[i] <= addr_lut_dst;
                end else begin
                    wr_dst_r[i] <= wr_dst_r[i];
                end
                if (rd_inc_s && (tid_s == TW'(i))) begin
                    rd_dst_r[i] <= addr_lut_dst;
                end else begin
                    rd_dst_r[i] <= rd_dst_r[i];
                end
            end
        end
    end

    axi_req_merge_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .b_done_valid (b_done_valid),
        .b_done_zero  (b_zero_s),
        .r_done_valid (r_done_valid),
        .r_done_zero  (r_zero_s)
    );

endmodule

// Simulation checks for the outstanding tables.
module axi_req_merge_chk (
    input logic clk,
    input logic rst,
    input logic b_done_valid,
    input logic b_done_zero,
    input logic r_done_valid,
    input logic r_done_zero
);

    // A response may only retire a transaction that is counted as outstanding.
    a_b_underflow: assert property (@(posedge clk) disable iff (rst)
                                    !(b_done_valid && b_done_zero))
        else $error("axi_req_merge: write done on TID with zero outstanding");

    a_r_underflow: assert property (@(posedge clk) disable iff (rst)
                                    !(r_done_valid && r_done_zero))
        else $error("axi_req_merge: read done on TID with zero outstanding");

endmodule
